instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the control/decode unit: holds the PC, issues one
//  instruction-memory read at a time over a valid/ready request channel,
//  captures the returned word into a one-entry output register and presents
//  {pc, instr} to decode with valid/ready. Applies PC redirects from branch,
//  jal and jalr resolution, and discards stale in-flight fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of the first fetch after reset
//  PC_STEP    4              sequential PC increment, in bytes
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   imem accepts request this cycle
//  imem_req_addr    out  32  fetch byte address, word aligned
//  imem_resp_valid  in   1   one-cycle pulse: read data valid
//  imem_resp_data   in   32  returned instruction word
//  redirect_valid   in   1   one-cycle pulse: branch/jal/jalr taken
//  redirect_pc      in   32  redirect target
//  out_valid        out  1   {out_pc, out_instr} valid for decode
//  out_ready        in   1   decode consumes the entry this cycle
//  out_pc           out  32  PC of out_instr
//  out_instr        out  32  instruction word to decode
//  fetch_count      out  32  number of instructions delivered (handshakes)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, kill=0, out_valid=0,
//   out_pc=0, out_instr=32'b0, fetch_count=0; imem_req_valid=0.
//  States: IDLE, REQ, WAIT. IDLE -> REQ unconditionally on the first edge
//   after rst_n rises.
//  REQ: imem_req_valid = !out_valid || out_ready (combinational), addr = pc.
//   On req_valid && req_ready -> WAIT. No other exit except redirect.
//  WAIT: at most one request outstanding. On resp_valid with kill=0:
//   out_valid<=1, out_pc<=pc, out_instr<=resp_data, pc<=pc+PC_STEP, -> REQ.
//   On resp_valid with kill=1: drop data, kill<=0, -> REQ (pc unchanged).
//  Issue rule guarantees output slot is empty (or drained the same cycle)
//   when the response lands; response is never lost or stalled.
//  Decode handshake: out_valid && out_ready clears out_valid (unless refilled
//   same cycle) and increments fetch_count (wraps 2^32-1 -> 0).
//  out_pc/out_instr hold stable while out_valid && !out_ready.
//  Redirect (highest priority, any state except IDLE):
//   pc <= {redirect_pc[31:2],2'b00} (low bits forced to zero);
//   out_valid <= 0 (flush, no fetch_count increment even if out_ready=1).
//   In REQ with req handshake same cycle -> WAIT, kill<=1.
//   In REQ without handshake -> stay REQ, kill unchanged (0).
//   In WAIT without resp_valid -> stay WAIT, kill<=1.
//   In WAIT with resp_valid same cycle -> data dropped, kill<=0, -> REQ.
//   Redirect in IDLE is ignored.
//  resp_valid outside WAIT is ignored. pc adds wrap modulo 2^32.
//  Latency: request accept -> out_valid is response latency + 1 cycle.
//  Reset mid-operation: all state cleared; a late response is ignored.
// TESTING
//  1 RESET_PC=0, req_ready=1, resp 1 cycle later 0x00500093 -> out_valid=1,
//    out_pc=0, out_instr=0x00500093; next req addr=0x4.
//  2 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable,
//    imem_req_valid=0, pc stays 0x4, fetch_count unchanged.
//  3 redirect 0x100 while WAIT, then resp 0xDEADBEEF -> word dropped,
//    out_valid stays 0, next req addr=0x100.
//  4 redirect 0x103 same cycle as req handshake at 0x8 -> response dropped,
//    next req addr=0x100.
//  5 redirect while out_valid=1 && out_ready=1 -> out_valid=0 next cycle,
//    fetch_count not incremented.
//  6 rst_n low in WAIT, resp pulse after release in IDLE -> ignored; first
//    req addr=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage with PC, single-outstanding imem request channel,
//               one-entry {pc, instr} output register and redirect handling.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] c_PC_STEP = PC_STEP[31:0];

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic [31:0] r_fetch_count;

  logic        w_req_valid;
  logic        w_req_fire;
  logic        w_deq;
  logic        w_redir;
  logic [31:0] w_redir_pc;

  // A request is only issued when the output slot will be free by the time
  // the response can land, so the response path never needs to stall.
  assign w_req_valid = (r_state == ST_REQ) && (!r_out_valid || out_ready);
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_deq       = r_out_valid && out_ready;
  assign w_redir     = redirect_valid && (r_state != ST_IDLE);
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_kill        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'h0;
      r_out_instr   <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      if (w_deq) begin
        r_out_valid <= 1'b0;
      end
      if (w_deq && !w_redir) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
        end

        ST_REQ: begin
          if (w_redir) begin
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
            if (w_req_fire) begin
              r_state <= ST_WAIT;
              r_kill  <= 1'b1;
            end
          end else if (w_req_fire) begin
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (w_redir) begin
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
            if (imem_resp_valid) begin
              r_kill  <= 1'b0;
              r_state <= ST_REQ;
            end else begin
              r_kill  <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            r_state <= ST_REQ;
            if (r_kill) begin
              r_kill <= 1'b0;
            end else begin
              r_out_valid <= 1'b1;
              r_out_pc    <= r_pc;
              r_out_instr <= imem_resp_data;
              r_pc        <= r_pc + c_PC_STEP;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign out_valid      = r_out_valid;
  assign out_pc         = r_out_pc;
  assign out_instr      = r_out_instr;
  assign fetch_count    = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench with a delivery scoreboard for instr_fetch_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: every accepted (non-flushed) decode handshake pops one entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL deliver: got pc=0x%08h instr=0x%08h expected nothing", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          n_fail++;
          $display("FAIL deliver: got pc=0x%08h instr=0x%08h expected pc=0x%08h instr=0x%08h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b1;
    tick();                                   // IDLE -> REQ

    // 1: basic fetch at RESET_PC
    imem_req_ready = 1'b1; settle();
    chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h0);
    tick();                                   // accept -> WAIT
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    exp_q.push_back({32'h0, 32'h0050_0093});
    settle();
    chk("t1_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();                                   // capture
    imem_resp_valid = 1'b0; settle();
    chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_out_pc", out_pc, 32'h0);
    chk("t1_out_instr", out_instr, 32'h0050_0093);
    chk("t1_next_addr", imem_req_addr, 32'h4);

    // 2: decode stall holds everything
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_out_valid", {31'b0, out_valid}, 32'd1);
      chk("t2_out_pc", out_pc, 32'h0);
      chk("t2_out_instr", out_instr, 32'h0050_0093);
      chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("t2_pc", imem_req_addr, 32'h4);
      chk("t2_fetch_count", fetch_count, 32'd0);
    end
    out_ready = 1'b1; imem_req_ready = 1'b1; settle();
    chk("t2_drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    tick();                                   // deliver + accept req @0x4
    imem_req_ready = 1'b0; settle();
    chk("t2_fetch_count_inc", fetch_count, 32'd1);
    chk("t2_out_valid_clr", {31'b0, out_valid}, 32'd0);

    // 3: redirect while WAIT kills the outstanding response
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0; settle();
    chk("t3_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t3_req_addr", imem_req_addr, 32'h100);

    // redirect in REQ without handshake: pc moves, stay REQ
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
    tick();
    redirect_valid = 1'b0; settle();
    chk("t4_pre_addr", imem_req_addr, 32'h8);
    chk("t4_pre_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // 4: redirect to unaligned 0x103 in the same cycle as req handshake at 0x8
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b0; settle();
    chk("t4_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    tick();
    imem_resp_valid = 1'b0; settle();
    chk("t4_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_req_addr", imem_req_addr, 32'h100);
    chk("t4_fetch_count", fetch_count, 32'd1);

    // fill the slot at 0x100 with decode stalled
    out_ready = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0113;
    tick();
    imem_resp_valid = 1'b0; settle();
    chk("t5_fill_valid", {31'b0, out_valid}, 32'd1);
    chk("t5_fill_pc", out_pc, 32'h100);

    // 5: redirect during a decode handshake flushes without counting
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0; settle();
    chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_fetch_count", fetch_count, 32'd1);
    chk("t5_req_addr", imem_req_addr, 32'h200);

    // two-cycle response latency, delivered immediately
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    exp_q.push_back({32'h200, 32'h1234_5678});
    tick();
    imem_resp_valid = 1'b0; settle();
    chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_out_pc", out_pc, 32'h200);
    chk("lat_next_addr", imem_req_addr, 32'h204);
    chk("lat_drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    tick();
    chk("lat_fetch_count", fetch_count, 32'd2);
    chk("lat_out_valid_clr", {31'b0, out_valid}, 32'd0);

    // 6: reset in WAIT, late response while IDLE is ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0; settle();
    chk("t6_async_fetch_count", fetch_count, 32'd0);
    chk("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    rst_n = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
    tick();
    imem_resp_valid = 1'b0; settle();
    chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_req_addr", imem_req_addr, 32'h0);
    chk("t6_fetch_count", fetch_count, 32'd0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    exp_q.push_back({32'h0, 32'h0050_0093});
    tick();
    imem_resp_valid = 1'b0;
    tick();
    chk("t6_fetch_count_after", fetch_count, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
